// File: rtl/arb_pkg.sv
// Shared types and sizing for the eight-requester round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ  = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: the first set request after ptr, with wrap-around.
module rr_priority_encoder
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W-1:0]   src;

    // rot[0] is the requester just after ptr, so the previous owner sits in rot[7].
    always_comb begin
        rot = '0;
        off = '0;
        src = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src    = ptr + IDX_W'(i) + IDX_W'(1);
            rot[i] = req[src];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = ptr + off + IDX_W'(1);
        any = |req;
    end

endmodule

// File: rtl/eight_request_arbiter.sv
// Round-robin arbiter for 8 requesters with held, exclusive grants.
// Define ARB_TIMEOUT_EN to add a watchdog that revokes a grant after MAX_HOLD cycles.
module eight_request_arbiter
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    // Protocol: req is a level; the owner keeps req[owner] high for as long as it
    // wants the resource and ends its tenure by dropping it or by a release_i pulse.
    // Each grant is followed by one GAP cycle before the next search.
    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               owner_done;

    rr_priority_encoder u_enc (
        .req (req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    assign owner_done = !req[grant_idx] || release_i;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant       <= NUM_REQ'(1) << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        ptr         <= win_idx;
                        state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A voluntary exit wins over a watchdog expiry on the same edge.
                    if (owner_done) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= GAP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        state       <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eight_request_arbiter.sv
// Self-checking bench for eight_request_arbiter (default build and ARB_TIMEOUT_EN build).
module tb_eight_request_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       release_i = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [12:0] exp_q[$];

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       tmo;
        string      name;
    } vec_t;

    vec_t vecs[$];

    eight_request_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard compare
    task automatic check_out(input string name);
        logic [12:0] act;
        logic [12:0] expv;
        act = {grant, grant_idx, grant_valid, timeout};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, expected queue empty",
                     name, grant, grant_idx, grant_valid, timeout);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                tests_failed++;
                $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, expected grant=%h idx=%0d valid=%b timeout=%b",
                         name, grant, grant_idx, grant_valid, timeout,
                         expv[12:5], expv[4:2], expv[1], expv[0]);
            end
        end
    endtask

    // Driver: inputs held across one rising edge, outputs checked 1 time unit later.
    task automatic step(input logic [7:0] r, input logic rl, input logic [7:0] eg,
                        input logic [2:0] ei, input logic ev, input logic et,
                        input string name);
        req       = r;
        release_i = rl;
        exp_q.push_back({eg, ei, ev, et});
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic add(input logic [7:0] r, input logic rl, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev, input logic et,
                       input string name);
        vec_t v;
        v.req = r; v.rel = rl; v.grant = eg; v.idx = ei; v.valid = ev; v.tmo = et; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].rel, vecs[i].grant, vecs[i].idx,
                 vecs[i].valid, vecs[i].tmo, vecs[i].name);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        req       = 8'h00;
        release_i = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(13'h0);
        check_out("reset_state");
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] o;
        int         hold;

        // Test 1: single requester, drop request, gap cycle
        do_reset();
        add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "t1_grant");
        add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "t1_hold");
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "t1_drop");
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "t1_gap");
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "t1_idle");
        add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t1_idle_release_ignored");
        run_table();

        // Test 2: all requesting, rotation 0..7 then wrap to 0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            o = 3'(k % 8);
            step(8'hFF, 1'b0, 8'h01 << o, o, 1'b1, 1'b0, "t2_grant");
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                step(8'hFF, 1'b0, 8'h01 << o, o, 1'b1, 1'b0, "t2_hold");
            end
            step(8'hFF, 1'b1, 8'h00, o, 1'b0, 1'b0, "t2_release");
            step(8'hFF, 1'b0, 8'h00, o, 1'b0, 1'b0, "t2_gap");
        end

        // Test 3: fairness after owner 3, then lone re-request
        do_reset();
        add(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "t3_owner3");
        add(8'h18, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "t3_release");
        add(8'h18, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, "t3_gap");
        add(8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "t3_next_is_4");
        add(8'h08, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, "t3_owner4_drops");
        add(8'h08, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, "t3_gap2");
        add(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "t3_back_to_3");
        add(8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "t3_release2");
        add(8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, "t3_gap3");
        add(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "t3_lone_rewin");
        // drop and release together: one exit only
        add(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "t3_both_exit");
        add(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, "t3_gap4");
        add(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, "t3_idle");
        run_table();

        // Test 4: no preemption by req[2] while owner 5 busy or in gap
        add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "t4_owner5");
        add(8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "t4_no_preempt_a");
        add(8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "t4_no_preempt_b");
        add(8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "t4_no_preempt_c");
        add(8'h24, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "t4_release");
        add(8'h24, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, "t4_gap_ignores_req2");
        add(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "t4_serve_2");
        run_table();

`ifdef ARB_TIMEOUT_EN
        // Test 5: watchdog revokes owner 6 after 16 cycles
        do_reset();
        step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "t5_grant6");
        for (int h = 0; h < 15; h++) begin
            step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "t5_hold");
        end
        step(8'h41, 1'b0, 8'h00, 3'd6, 1'b0, 1'b1, "t5_expire");
        step(8'h41, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0, "t5_gap_timeout_clear");
        step(8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "t5_next_is_0");
        for (int h = 0; h < 15; h++) begin
            step(8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "t5_hold0");
        end
        step(8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "t5_release_beats_expiry");
        step(8'h41, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "t5_gap2");
        step(8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "t5_next_is_6");
`else
        // Without the watchdog a grant is held indefinitely
        do_reset();
        step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "t5_grant6");
        for (int h = 0; h < 40; h++) begin
            step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "t5_held_no_timeout");
        end
        step(8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0, "t5_drop");
`endif

        // Test 6: asynchronous reset while owner 2 is busy
        do_reset();
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "t6_owner2");
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "t6_hold");
        rst = 1'b1;
        #2;
        exp_q.push_back(13'h0);
        check_out("t6_async_clear");
        req = 8'h84;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "t6_ptr_reset_pick_2");

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
